// File: rtl/frame_capture_ctrl_if.sv
// Handshake bundle between the color mapper / network side and the frame capture controller.
// The controller takes the slave modport; whoever drives the strobes takes master.
interface frame_capture_ctrl_if #(
    parameter int ADDR_W = 13
);
    logic              Arm;
    logic              Cont;
    logic              RstH;
    logic              Get;
    logic              Get_done;
    logic              x_values;
    logic              Nn_done;
    logic              Wr_en;
    logic [ADDR_W-1:0] Wr_addr;
    logic              Wr_data;
    logic              Nn_start;
    logic              Busy;
    logic              Cap_err;
    logic              Frame_done;

    modport master (
        output Arm, Cont, RstH, Get, Get_done, x_values, Nn_done,
        input  Wr_en, Wr_addr, Wr_data, Nn_start, Busy, Cap_err, Frame_done
    );

    modport slave (
        input  Arm, Cont, RstH, Get, Get_done, x_values, Nn_done,
        output Wr_en, Wr_addr, Wr_data, Nn_start, Busy, Cap_err, Frame_done
    );
endinterface

// File: rtl/frame_capture_ctrl.sv
// Captures one subsampled frame window into the sample buffer, then hands it to the network.
// Sample writes are registered one cycle after the accepted Get; Cap_err is sticky until re-armed.
module frame_capture_ctrl #(
    parameter int SAMPLE_COUNT = 8000,
    parameter int ADDR_W       = 13
) (
    input  logic                 Clk,
    input  logic                 RST,
    frame_capture_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_SOF = 3'd1,
        MARK     = 3'd2,
        CAPTURE  = 3'd3,
        START    = 3'd4,
        INFER    = 3'd5
    } state_t;

    localparam logic [ADDR_W-1:0] LP_SC = ADDR_W'(SAMPLE_COUNT);

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] w_cnt_nxt;
    logic              w_accept;
    logic              w_err_set;
    logic              w_cnt_clr;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic              r_wr_data;
    logic              r_cap_err;
    logic              r_frame_done;

    // A window restart (RstH) in CAPTURE suppresses the sample in that cycle.
    assign w_accept  = (r_state == CAPTURE) && !bus.RstH && bus.Get && (r_cnt < LP_SC);
    assign w_cnt_nxt = w_accept ? (r_cnt + ADDR_W'(1)) : r_cnt;

    always_ff @(posedge Clk) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_err_set = 1'b0;
        w_cnt_clr = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.Arm) w_next = WAIT_SOF;
            end
            WAIT_SOF: begin
                if (bus.RstH) begin
                    w_cnt_clr = 1'b1;
                    w_next    = MARK;
                end
            end
            MARK: begin
                if (bus.RstH) begin
                    w_cnt_clr = 1'b1;
                end else if (bus.Get_done) begin
                    w_err_set = 1'b1;
                    w_next    = WAIT_SOF;
                end else if (bus.Get) begin
                    w_next = CAPTURE;
                end
            end
            CAPTURE: begin
                if (bus.RstH) begin
                    w_cnt_clr = 1'b1;
                    w_next    = MARK;
                end else begin
                    if (bus.Get && (r_cnt >= LP_SC)) w_err_set = 1'b1;
                    // Get_done compares against the count including a same-cycle sample.
                    if (bus.Get_done) begin
                        if (w_cnt_nxt == LP_SC) begin
                            w_next = START;
                        end else begin
                            w_err_set = 1'b1;
                            w_next    = WAIT_SOF;
                        end
                    end
                end
            end
            START: begin
                w_next = INFER;
            end
            INFER: begin
                if (bus.Nn_done) w_next = bus.Cont ? WAIT_SOF : IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_comb begin
        bus.Busy     = (r_state != IDLE);
        bus.Nn_start = (r_state == START);
    end

    always_ff @(posedge Clk) begin
        if (RST) begin
            r_cnt        <= '0;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= 1'b0;
            r_cap_err    <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_cnt        <= w_cnt_clr ? '0 : w_cnt_nxt;
            r_wr_en      <= w_accept;
            r_frame_done <= (r_state == INFER) && bus.Nn_done;
            if (w_accept) begin
                r_wr_addr <= r_cnt;
                r_wr_data <= bus.x_values;
            end
            if ((r_state == IDLE) && bus.Arm) begin
                r_cap_err <= 1'b0;
            end else if (w_err_set) begin
                r_cap_err <= 1'b1;
            end
        end
    end

    assign bus.Wr_en      = r_wr_en;
    assign bus.Wr_addr    = r_wr_addr;
    assign bus.Wr_data    = r_wr_data;
    assign bus.Cap_err    = r_cap_err;
    assign bus.Frame_done = r_frame_done;
endmodule

// File: tb/tb_frame_capture_ctrl.sv
// Directed bench for frame_capture_ctrl with SAMPLE_COUNT=8: a vector table for the main
// frame/continuous flow plus hand-written sequences for short, long, restart and reset cases.
module tb_frame_capture_ctrl;
    localparam int SC = 8;
    localparam int AW = 4;

    typedef struct packed {
        logic rst, arm, cont, rsth, get, gd, x, nnd;
    } in_t;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic          data;
        logic          ns;
        logic          busy;
        logic          err;
        logic          fd;
    } out_t;

    typedef struct {
        in_t   i;
        out_t  o;
        string nm;
    } vec_t;

    logic Clk;
    logic RST;
    int   checks;
    int   errors;
    vec_t tbl[$];

    frame_capture_ctrl_if #(.ADDR_W(AW)) bus ();

    frame_capture_ctrl #(.SAMPLE_COUNT(SC), .ADDR_W(AW)) dut (
        .Clk (Clk),
        .RST (RST),
        .bus (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, actual running required done");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input in_t v);
        RST          = v.rst;
        bus.Arm      = v.arm;
        bus.Cont     = v.cont;
        bus.RstH     = v.rsth;
        bus.Get      = v.get;
        bus.Get_done = v.gd;
        bus.x_values = v.x;
        bus.Nn_done  = v.nnd;
        @(posedge Clk);
        #1;
    endtask

    task automatic expect_out(input string nm, input out_t exp);
        out_t act;
        out_t msk;
        act = {bus.Wr_en, bus.Wr_addr, bus.Wr_data, bus.Nn_start, bus.Busy, bus.Cap_err, bus.Frame_done};
        msk = exp.we ? '1 : {1'b1, {AW{1'b0}}, 1'b0, 4'b1111};
        checks++;
        if ((act & msk) !== (exp & msk)) begin
            errors++;
            $display("FAIL %s: actual we=%b addr=%0d data=%b ns=%b busy=%b err=%b fd=%b required we=%b addr=%0d data=%b ns=%b busy=%b err=%b fd=%b",
                     nm, act.we, act.addr, act.data, act.ns, act.busy, act.err, act.fd,
                     exp.we, exp.addr, exp.data, exp.ns, exp.busy, exp.err, exp.fd);
        end
    endtask

    // step + check in one call
    task automatic sc(input string nm, input in_t v, input out_t exp);
        cyc(v);
        expect_out(nm, exp);
    endtask

    function automatic out_t o_busy(input logic err);
        return {1'b0, {AW{1'b0}}, 1'b0, 1'b0, 1'b1, err, 1'b0};
    endfunction

    function automatic out_t o_wr(input int a, input logic d, input logic err);
        return {1'b1, AW'(a), d, 1'b0, 1'b1, err, 1'b0};
    endfunction

    localparam in_t I_NONE = 8'b0000_0000;
    localparam in_t I_RST  = 8'b1000_0000;
    localparam in_t I_ARM  = 8'b0100_0000;
    localparam in_t I_RSTH = 8'b0001_0000;
    localparam in_t I_GET  = 8'b0000_1000;
    localparam in_t I_GD   = 8'b0000_0100;
    localparam in_t I_X    = 8'b0000_0010;
    localparam in_t I_NND  = 8'b0000_0001;
    localparam in_t I_CONT = 8'b0010_0000;
    localparam out_t O_ZERO = '0;

    task automatic open_frame(input string nm);
        sc({nm, "_arm"},    I_ARM,  o_busy(1'b0));
        sc({nm, "_rsth"},   I_RSTH, o_busy(1'b0));
        sc({nm, "_marker"}, I_GET | I_X, o_busy(1'b0));
    endtask

    initial begin
        logic [7:0] pat;
        out_t       o;
        checks = 0;
        errors = 0;
        pat    = 8'b0100_1101;  // bit i = x for sample i: 1,0,1,1,0,0,1,0
        cyc(I_NONE);

        // Main table: full frame, inference, continuous re-arm.
        tbl.push_back('{8'b1101_1111, O_ZERO, "rst_priority"});
        tbl.push_back('{I_ARM,  o_busy(1'b0), "arm"});
        tbl.push_back('{I_RSTH, o_busy(1'b0), "rsth"});
        tbl.push_back('{I_GET | I_X, o_busy(1'b0), "marker_no_write"});
        for (int i = 0; i < SC; i++) begin
            tbl.push_back('{I_GET | (pat[i] ? I_X : I_NONE), o_wr(i, pat[i], 1'b0), $sformatf("write%0d", i)});
        end
        o = o_busy(1'b0); o.ns = 1'b1;
        tbl.push_back('{I_GD, o, "nn_start"});
        tbl.push_back('{I_NONE, o_busy(1'b0), "infer0"});
        tbl.push_back('{I_ARM | I_RSTH | I_GET, o_busy(1'b0), "infer_ignores"});
        o = o_busy(1'b0); o.fd = 1'b1;
        tbl.push_back('{I_CONT | I_NND, o, "frame_done_cont"});
        tbl.push_back('{I_CONT, o_busy(1'b0), "frame_done_pulse"});
        tbl.push_back('{I_CONT | I_RSTH, o_busy(1'b0), "cont_rsth"});
        tbl.push_back('{I_CONT | I_GET, o_busy(1'b0), "cont_marker"});
        tbl.push_back('{I_CONT | I_GET | I_X, o_wr(0, 1'b1, 1'b0), "cont_addr0"});
        tbl.push_back('{I_RST, O_ZERO, "rst_end"});
        foreach (tbl[k]) sc(tbl[k].nm, tbl[k].i, tbl[k].o);

        // Short window: 7 samples then Get_done.
        open_frame("short");
        for (int i = 0; i < SC - 1; i++) sc("short_wr", I_GET, o_wr(i, 1'b0, 1'b0));
        sc("short_gd", I_GD, o_busy(1'b1));
        sc("short_waitsof_ignores", I_GET | I_GD | I_X, o_busy(1'b1));
        sc("short_rsth", I_RSTH, o_busy(1'b1));
        sc("short_marker", I_GET, o_busy(1'b1));
        sc("short_recap_addr0", I_GET | I_X, o_wr(0, 1'b1, 1'b1));
        sc("short_rst", I_RST, O_ZERO);

        // Long window: 9 samples, 9th dropped, inference still starts.
        open_frame("long");
        for (int i = 0; i < SC; i++) sc("long_wr", I_GET | I_X, o_wr(i, 1'b1, 1'b0));
        sc("long_9th_dropped", I_GET, o_busy(1'b1));
        o = o_busy(1'b1); o.ns = 1'b1;
        sc("long_nn_start", I_GD, o);
        sc("long_infer", I_NONE, o_busy(1'b1));
        o = O_ZERO; o.err = 1'b1; o.fd = 1'b1;
        sc("long_done_idle", I_NND, o);
        sc("arm_clears_err", I_ARM, o_busy(1'b0));
        sc("long_rst", I_RST, O_ZERO);

        // Get and Get_done together on the last sample.
        open_frame("same");
        for (int i = 0; i < SC - 1; i++) sc("same_wr", I_GET, o_wr(i, 1'b0, 1'b0));
        o = o_wr(SC - 1, 1'b1, 1'b0); o.ns = 1'b1;
        sc("same_get_gd", I_GET | I_GD | I_X, o);
        sc("same_rst", I_RST, O_ZERO);

        // Reset mid-capture, then RstH without Arm must not write.
        open_frame("midrst");
        for (int i = 0; i < 4; i++) sc("midrst_wr", I_GET | I_X, o_wr(i, 1'b1, 1'b0));
        sc("midrst_rst", I_RST | I_GET | I_X, O_ZERO);
        sc("noarm_rsth", I_RSTH, O_ZERO);
        sc("noarm_get0", I_GET | I_X, O_ZERO);
        sc("noarm_get1", I_GET | I_X, O_ZERO);

        // Window restart after 3 writes.
        open_frame("restart");
        for (int i = 0; i < 3; i++) sc("restart_wr", I_GET, o_wr(i, 1'b0, 1'b0));
        sc("restart_rsth_nowrite", I_RSTH | I_GET | I_X, o_busy(1'b0));
        sc("restart_marker", I_GET | I_X, o_busy(1'b0));
        sc("restart_idle_gap", I_NONE, o_busy(1'b0));
        sc("restart_addr0", I_GET | I_X, o_wr(0, 1'b1, 1'b0));
        sc("restart_rst", I_RST, O_ZERO);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/frame_capture_ctrl.md
FRAME_CAPTURE_CTRL -- requirements
Module: frame_capture_ctrl

Interface
REQ-001 SHALL provide parameter SAMPLE_COUNT, default 8000, meaning the number of subsampled pixels per frame window (100x160 box, checkerboard).
REQ-002 SHALL provide parameter ADDR_W, default 13, meaning the width of the sample-buffer address and sample counter.
REQ-003 SHALL provide port Clk, input, 1, the pixel clock; the only clock in the block.
REQ-004 SHALL provide port RST, input, 1, reset; synchronous, active-high.
REQ-005 SHALL provide port Arm, input, 1, one-cycle request to capture one frame.
REQ-006 SHALL provide port Cont, input, 1, continuous mode: re-arm automatically after each inference.
REQ-007 SHALL provide port RstH, input, 1, start-of-window strobe from the color mapper.
REQ-008 SHALL provide port Get, input, 1, sample strobe; the first Get after RstH is a marker, not a sample.
REQ-009 SHALL provide port Get_done, input, 1, end-of-window strobe.
REQ-010 SHALL provide port x_values, input, 1, thresholded pixel bit, valid in the cycle Get=1.
REQ-011 SHALL provide port Nn_done, input, 1, one-cycle completion pulse from the network.
REQ-012 SHALL provide port Wr_en, output, 1, sample-buffer write enable.
REQ-013 SHALL provide port Wr_addr, output, ADDR_W, sample-buffer write address.
REQ-014 SHALL provide port Wr_data, output, 1, sample bit to write.
REQ-015 SHALL provide port Nn_start, output, 1, one-cycle inference start pulse.
REQ-016 SHALL provide port Busy, output, 1, high in every state except IDLE.
REQ-017 SHALL provide port Cap_err, output, 1, sticky flag set when a window's sample count is not SAMPLE_COUNT.
REQ-018 SHALL provide port Frame_done, output, 1, one-cycle pulse when Nn_done is accepted.

Function
REQ-019 SHALL implement the states IDLE, WAIT_SOF, MARK, CAPTURE, START and INFER.
REQ-020 In IDLE, Arm=1 SHALL cause a transition to WAIT_SOF; in all other states Arm SHALL be ignored.
REQ-021 In WAIT_SOF, RstH=1 SHALL clear the counter to 0 and cause a transition to MARK; Get and Get_done SHALL be ignored in this state.
REQ-022 In MARK, Get=1 SHALL cause a transition to CAPTURE without writing; Get_done=1 SHALL set Cap_err and return the block to WAIT_SOF.
REQ-023 In CAPTURE, Get=1 with counter<SAMPLE_COUNT SHALL register Wr_en=1, Wr_addr=counter and Wr_data=x_values in the next cycle (latency 1), then increment the counter.
REQ-024 In CAPTURE, Get=1 with counter=SAMPLE_COUNT SHALL produce no write, SHALL set Cap_err, and SHALL hold the counter (saturating).
REQ-025 In CAPTURE, on Get_done=1: if counter=SAMPLE_COUNT, SHALL move to START; otherwise SHALL set Cap_err and move to WAIT_SOF.
REQ-026 If Get and Get_done are both high in CAPTURE, the Get sample SHALL be processed first and the counter compare SHALL use the incremented value.
REQ-027 In CAPTURE, RstH=1 SHALL clear the counter and move to MARK (window restart); no write SHALL occur in that cycle.
REQ-028 START SHALL assert Nn_start for exactly one cycle, then move to INFER.
REQ-029 In INFER, Nn_done=1 SHALL pulse Frame_done; next state is WAIT_SOF if Cont=1, else IDLE; all other inputs SHALL be ignored.
REQ-030 Wr_en SHALL be high only in the cycle after an accepted sample, and SHALL never be high in two consecutive cycles unless two consecutive Gets are accepted.
REQ-031 Cap_err SHALL clear only on RST or on Arm accepted in IDLE.

Reset
REQ-032 RST=1 at a rising Clk edge SHALL force state IDLE, counter 0, and Wr_en, Wr_addr, Wr_data, Nn_start, Busy, Cap_err, Frame_done all 0, including mid-CAPTURE or mid-INFER.
REQ-033 RST SHALL take priority over every other input in the same cycle.

Verification
REQ-034 Bench SHALL cover: SAMPLE_COUNT=8, Arm, RstH, marker Get, 8 Gets with x_values=1,0,1,1,0,0,1,0, Get_done -> writes to addr 0..7 with that data, one cycle after each Get; one Nn_start pulse; Cap_err=0.
REQ-035 Bench SHALL cover: SAMPLE_COUNT=8 with only 7 Gets before Get_done -> Cap_err=1, no Nn_start, Busy=1, state WAIT_SOF.
REQ-036 Bench SHALL cover: 9 Gets -> 8 writes, no write for the 9th Get, Cap_err=1, and Nn_start after Get_done.
REQ-037 Bench SHALL cover: Cont=1, Nn_done -> Frame_done pulse, Busy stays 1, and the next RstH starts a new capture at addr 0.
REQ-038 Bench SHALL cover: RST asserted after 4 writes -> all outputs 0 next cycle, and a later RstH without Arm produces no writes.
REQ-039 Bench SHALL cover: RstH after 3 writes in CAPTURE -> after the new marker, the next write goes to addr 0.
